// File: rtl/bu_arb_ctrl.sv
// rtl/bu_arb_ctrl.sv - two-port round-robin arbiter around a shared branch comparator
// Optional feature macro: BU_ARB_PREDICT_EN (per-port prediction input, mispredict output)

module bu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic        taken,
  output logic        illegal
);
  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLT  = 3'b100;
  localparam logic [2:0] OP_BGE  = 3'b101;
  localparam logic [2:0] OP_BLTU = 3'b110;
  localparam logic [2:0] OP_BGEU = 3'b111;

  // Evaluate the branch condition; unknown encodings never take and raise illegal
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_BEQ:  taken = (a == b);
      OP_BNE:  taken = (a != b);
      OP_BLT:  taken = ($signed(a) < $signed(b));
      OP_BGE:  taken = ($signed(a) >= $signed(b));
      OP_BLTU: taken = (a < b);
      OP_BGEU: taken = (a >= b);
      default: illegal = 1'b1;
    endcase
  end
endmodule

module bu_arb_ctrl #(
  parameter int TAG_W = 4,
  parameter int XLEN  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic [1:0]           i_req_valid,
  output logic [1:0]           o_req_ready,
  input  logic [2*XLEN-1:0]    i_req_a,
  input  logic [2*XLEN-1:0]    i_req_b,
  input  logic [5:0]           i_req_op,
  input  logic [2*XLEN-1:0]    i_req_pc,
  input  logic [2*XLEN-1:0]    i_req_imm,
  input  logic [2*TAG_W-1:0]   i_req_tag,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic                 o_res_taken,
  output logic [XLEN-1:0]      o_res_next_pc,
  output logic [TAG_W-1:0]     o_res_tag,
  output logic                 o_res_src,
  output logic                 o_res_illegal
`ifdef BU_ARB_PREDICT_EN
  ,
  input  logic [1:0]           i_req_pred,
  output logic                 o_res_mispredict
`endif
);
  // Result register occupancy; the comparator is 32-bit so XLEN stays 32
  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic             state;
  logic             ptr;
  logic             can_accept;
  logic             accept;
  logic             win;
  logic [XLEN-1:0]  sel_a;
  logic [XLEN-1:0]  sel_b;
  logic [XLEN-1:0]  sel_pc;
  logic [XLEN-1:0]  sel_imm;
  logic [XLEN-1:0]  next_pc;
  logic [2:0]       sel_op;
  logic [TAG_W-1:0] sel_tag;
  logic             cmp_taken;
  logic             cmp_illegal;

  assign o_res_valid = (state == FULL);

  // Accept only when the result slot is free now or drains on this edge
  assign can_accept = ~i_flush & (~o_res_valid | i_res_ready);

  // Pointer port wins when valid; otherwise the other port (valid if anything is)
  assign win         = i_req_valid[ptr] ? ptr : ~ptr;
  assign accept      = can_accept & (|i_req_valid);
  assign o_req_ready = {accept & win, accept & ~win};

  assign sel_a   = win ? i_req_a[2*XLEN-1:XLEN]   : i_req_a[XLEN-1:0];
  assign sel_b   = win ? i_req_b[2*XLEN-1:XLEN]   : i_req_b[XLEN-1:0];
  assign sel_pc  = win ? i_req_pc[2*XLEN-1:XLEN]  : i_req_pc[XLEN-1:0];
  assign sel_imm = win ? i_req_imm[2*XLEN-1:XLEN] : i_req_imm[XLEN-1:0];
  assign sel_op  = win ? i_req_op[5:3]            : i_req_op[2:0];
  assign sel_tag = win ? i_req_tag[2*TAG_W-1:TAG_W] : i_req_tag[TAG_W-1:0];

  bu u_bu (
    .a       (sel_a),
    .b       (sel_b),
    .op      (sel_op),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  // Illegal ops report not-taken from the comparator, so they fall through to pc+4
  assign next_pc = cmp_taken ? (sel_pc + sel_imm) : (sel_pc + {{(XLEN-3){1'b0}}, 3'd4});

  // Occupancy FSM and round-robin pointer; flush drops the held result without accepting
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= EMPTY;
      ptr   <= 1'b0;
    end else begin
      if (i_flush)
        state <= EMPTY;
      else if (accept)
        state <= FULL;
      else if (i_res_ready)
        state <= EMPTY;
      if (accept)
        ptr <= ~win;
    end
  end

  // Result payload only changes on accept, so it holds steady across stalls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_res_taken   <= 1'b0;
      o_res_next_pc <= '0;
      o_res_tag     <= '0;
      o_res_src     <= 1'b0;
      o_res_illegal <= 1'b0;
    end else if (accept) begin
      o_res_taken   <= cmp_taken;
      o_res_next_pc <= next_pc;
      o_res_tag     <= sel_tag;
      o_res_src     <= win;
      o_res_illegal <= cmp_illegal;
    end
  end

`ifdef BU_ARB_PREDICT_EN
  // Mispredict compares outcome against the winner's prediction; illegal ops never flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_res_mispredict <= 1'b0;
    else if (accept)
      o_res_mispredict <= cmp_illegal ? 1'b0 : (cmp_taken ^ (win ? i_req_pred[1] : i_req_pred[0]));
  end
`endif
endmodule

// File: tb/tb_bu_arb_ctrl.sv
// tb/tb_bu_arb_ctrl.sv - randomized self-checking bench for bu_arb_ctrl
module tb_bu_arb_ctrl;
  localparam int TAG_W = 4;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_flush = 1'b0;
  logic [1:0]        i_req_valid = 2'b00;
  logic              i_res_ready = 1'b0;
  logic [1:0]        o_req_ready;
  logic [63:0]       i_req_a, i_req_b, i_req_pc, i_req_imm;
  logic [5:0]        i_req_op;
  logic [2*TAG_W-1:0] i_req_tag;
  logic              o_res_valid, o_res_taken, o_res_src, o_res_illegal;
  logic [31:0]       o_res_next_pc;
  logic [TAG_W-1:0]  o_res_tag;
  logic [1:0]        rpred = 2'b00;
`ifdef BU_ARB_PREDICT_EN
  logic              o_res_mispredict;
`endif

  logic [31:0]      ra[2], rb[2], rpc[2], rimm[2];
  logic [2:0]       rop[2];
  logic [TAG_W-1:0] rtag[2];

  assign i_req_a   = {ra[1], ra[0]};
  assign i_req_b   = {rb[1], rb[0]};
  assign i_req_pc  = {rpc[1], rpc[0]};
  assign i_req_imm = {rimm[1], rimm[0]};
  assign i_req_op  = {rop[1], rop[0]};
  assign i_req_tag = {rtag[1], rtag[0]};

  int npass = 0;
  int ntotal = 0;

  bit               m_full;
  int               m_ptr;
  logic             m_taken, m_src, m_ill, m_misp;
  logic [31:0]      m_npc;
  logic [TAG_W-1:0] m_tag;

  bu_arb_ctrl #(.TAG_W(TAG_W), .XLEN(32)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_flush       (i_flush),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_a       (i_req_a),
    .i_req_b       (i_req_b),
    .i_req_op      (i_req_op),
    .i_req_pc      (i_req_pc),
    .i_req_imm     (i_req_imm),
    .i_req_tag     (i_req_tag),
    .o_res_valid   (o_res_valid),
    .i_res_ready   (i_res_ready),
    .o_res_taken   (o_res_taken),
    .o_res_next_pc (o_res_next_pc),
    .o_res_tag     (o_res_tag),
    .o_res_src     (o_res_src),
    .o_res_illegal (o_res_illegal)
`ifdef BU_ARB_PREDICT_EN
    ,
    .i_req_pred       (rpred),
    .o_res_mispredict (o_res_mispredict)
`endif
  );

  initial forever #5 i_clk = ~i_clk;

  // Branch rules from the RISC-V condition definitions
  task automatic bu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic t, output logic il);
    t = 1'b0;
    il = 1'b0;
    case (op)
      3'd0: t = (a == b);
      3'd1: t = (a != b);
      3'd4: t = ($signed(a) < $signed(b));
      3'd5: t = ($signed(a) >= $signed(b));
      3'd6: t = (a < b);
      3'd7: t = (a >= b);
      default: il = 1'b1;
    endcase
  endtask

  function automatic logic [1:0] exp_ready();
    int w;
    if (i_flush || (m_full && !i_res_ready) || i_req_valid == 2'b00) return 2'b00;
    w = i_req_valid[m_ptr] ? m_ptr : 1 - m_ptr;
    return (w == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    m_full = 0; m_ptr = 0; m_taken = 0; m_src = 0; m_ill = 0; m_misp = 0;
    m_npc = 0; m_tag = 0;
  endtask

  task automatic model_clock();
    logic [1:0] g;
    int w;
    logic t, il;
    g = exp_ready();
    if (i_flush) m_full = 0;
    else if (g != 2'b00) begin
      w = g[1] ? 1 : 0;
      bu_ref(rop[w], ra[w], rb[w], t, il);
      m_taken = t;
      m_ill = il;
      m_npc = t ? rpc[w] + rimm[w] : rpc[w] + 32'd4;
      m_tag = rtag[w];
      m_src = (w == 1);
      m_misp = il ? 1'b0 : (t ^ rpred[w]);
      m_full = 1;
      m_ptr = 1 - w;
    end else if (i_res_ready) m_full = 0;
  endtask

  task automatic tick();
    model_clock();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic set_port(input int p, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [TAG_W-1:0] tag);
    rop[p] = op; ra[p] = a; rb[p] = b; rpc[p] = pc; rimm[p] = imm; rtag[p] = tag;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic idle_drain();
    i_req_valid = 2'b00; i_flush = 1'b0; i_res_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    ntotal++;
    if ({o_res_valid, o_res_taken, o_res_next_pc, o_res_tag, o_res_src, o_res_illegal} !== '0)
      $display("FAIL reset_outputs: valid=%b taken=%b npc=%h tag=%h src=%b ill=%b want all 0",
               o_res_valid, o_res_taken, o_res_next_pc, o_res_tag, o_res_src, o_res_illegal);
    else npass++;
    @(negedge i_clk);
    set_port(0, 3'd0, 32'h5, 32'h5, 32'h40, 32'h10, 4'h3);
    i_req_valid = 2'b01; i_res_ready = 1'b0;
    tick();
    ntotal++;
    if (o_res_valid !== 1'b1) $display("FAIL fill_before_reset: valid=%b want 1", o_res_valid);
    else npass++;
    i_req_valid = 2'b00;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    ntotal++;
    if (o_res_valid !== 1'b0) $display("FAIL async_reset_valid: valid=%b want 0", o_res_valid);
    else npass++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_req_valid = 2'b11; i_res_ready = 1'b1;
    set_port(1, 3'd0, 32'h0, 32'h0, 32'h80, 32'h10, 4'h4);
    #1;
    ntotal++;
    if (o_req_ready !== 2'b01) $display("FAIL reset_pointer: ready=%b want 01", o_req_ready);
    else npass++;
    i_req_valid = 2'b00;
    @(negedge i_clk);
  endtask

  task automatic test_branch_ops();
    set_port(0, 3'd4, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 4'h5);
    i_req_valid = 2'b01; i_res_ready = 1'b1;
    #1;
    ntotal++;
    if (o_req_ready !== 2'b01) $display("FAIL blt_ready: ready=%b want 01", o_req_ready);
    else npass++;
    tick();
    ntotal++;
    if ({o_res_valid, o_res_taken, o_res_src, o_res_tag} !== {1'b1, 1'b1, 1'b0, 4'h5})
      $display("FAIL blt_result: valid=%b taken=%b src=%b tag=%h want 1 1 0 5",
               o_res_valid, o_res_taken, o_res_src, o_res_tag);
    else npass++;
    ntotal++;
    if (o_res_next_pc !== 32'h120) $display("FAIL blt_npc: npc=%h want 00000120", o_res_next_pc);
    else npass++;
    rop[0] = 3'd6;
    tick();
    ntotal++;
    if ({o_res_valid, o_res_taken, o_res_illegal} !== 3'b100)
      $display("FAIL bltu_result: valid=%b taken=%b ill=%b want 1 0 0",
               o_res_valid, o_res_taken, o_res_illegal);
    else npass++;
    ntotal++;
    if (o_res_next_pc !== 32'h104) $display("FAIL bltu_npc: npc=%h want 00000104", o_res_next_pc);
    else npass++;
    idle_drain();
  endtask

  task automatic test_round_robin();
    logic [1:0] want;
    do_reset();
    set_port(0, 3'd1, $urandom, $urandom, 32'h1000, 32'h8, 4'h1);
    set_port(1, 3'd0, 32'h7, 32'h7, 32'h2000, 32'hC, 4'h2);
    i_req_valid = 2'b11; i_res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      ntotal++;
      if (o_req_ready !== want) $display("FAIL rr_ready_%0d: ready=%b want %b", i, o_req_ready, want);
      else npass++;
      tick();
      ntotal++;
      if (o_res_valid !== 1'b1 || o_res_src !== want[1] || o_res_tag !== m_tag || o_res_next_pc !== m_npc)
        $display("FAIL rr_result_%0d: valid=%b src=%b tag=%h npc=%h want 1 %b %h %h",
                 i, o_res_valid, o_res_src, o_res_tag, o_res_next_pc, want[1], m_tag, m_npc);
      else npass++;
    end
    idle_drain();
  endtask

  task automatic test_stall();
    set_port(0, 3'd5, 32'h10, 32'h20, 32'h300, 32'h40, 4'hA);
    set_port(1, 3'd7, 32'h30, 32'h20, 32'h500, 32'h60, 4'hB);
    i_req_valid = 2'b01; i_res_ready = 1'b0;
    tick();
    i_req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      ntotal++;
      if (o_req_ready !== 2'b00) $display("FAIL stall_ready_%0d: ready=%b want 00", i, o_req_ready);
      else npass++;
      tick();
      ntotal++;
      if (o_res_valid !== 1'b1 || o_res_tag !== 4'hA || o_res_next_pc !== 32'h304 || o_res_taken !== 1'b0)
        $display("FAIL stall_hold_%0d: valid=%b tag=%h npc=%h taken=%b want 1 a 00000304 0",
                 i, o_res_valid, o_res_tag, o_res_next_pc, o_res_taken);
      else npass++;
    end
    i_res_ready = 1'b1;
    #1;
    ntotal++;
    if (o_req_ready !== 2'b10) $display("FAIL stall_release_ready: ready=%b want 10", o_req_ready);
    else npass++;
    tick();
    ntotal++;
    if (o_res_valid !== 1'b1 || o_res_src !== 1'b1 || o_res_tag !== 4'hB || o_res_next_pc !== 32'h560)
      $display("FAIL stall_refill: valid=%b src=%b tag=%h npc=%h want 1 1 b 00000560",
               o_res_valid, o_res_src, o_res_tag, o_res_next_pc);
    else npass++;
  endtask

  task automatic test_flush();
    set_port(1, 3'b010, 32'h1, 32'h1, 32'h200, 32'h40, 4'hC);
    i_req_valid = 2'b10; i_res_ready = 1'b0; i_flush = 1'b1;
    #1;
    ntotal++;
    if (o_req_ready !== 2'b00) $display("FAIL flush_ready: ready=%b want 00", o_req_ready);
    else npass++;
    tick();
    ntotal++;
    if (o_res_valid !== 1'b0) $display("FAIL flush_valid: valid=%b want 0", o_res_valid);
    else npass++;
    i_flush = 1'b0;
    #1;
    ntotal++;
    if (o_req_ready !== 2'b10) $display("FAIL post_flush_ready: ready=%b want 10", o_req_ready);
    else npass++;
    tick();
    ntotal++;
    if ({o_res_valid, o_res_illegal, o_res_taken, o_res_src} !== 4'b1101 || o_res_next_pc !== 32'h204)
      $display("FAIL illegal_op: valid=%b ill=%b taken=%b src=%b npc=%h want 1 1 0 1 00000204",
               o_res_valid, o_res_illegal, o_res_taken, o_res_src, o_res_next_pc);
    else npass++;
    idle_drain();
  endtask

  task automatic test_wrap();
    set_port(0, 3'd0, 32'h1234, 32'h1234, 32'hFFFF_FFFC, 32'h8, 4'h6);
    set_port(1, 3'd0, 32'h0, 32'h1, 32'h0, 32'h0, 4'h0);
    rpred = 2'b00;
    i_req_valid = 2'b01; i_res_ready = 1'b1;
    tick();
    ntotal++;
    if (o_res_valid !== 1'b1 || o_res_taken !== 1'b1 || o_res_next_pc !== 32'h4)
      $display("FAIL wrap_npc: valid=%b taken=%b npc=%h want 1 1 00000004",
               o_res_valid, o_res_taken, o_res_next_pc);
    else npass++;
`ifdef BU_ARB_PREDICT_EN
    ntotal++;
    if (o_res_mispredict !== 1'b1) $display("FAIL wrap_mispredict: got %b want 1", o_res_mispredict);
    else npass++;
`endif
    idle_drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < 2; p++) begin
        ra[p] = $urandom;
        rb[p] = ($urandom_range(0, 3) == 0) ? ra[p] : $urandom;
        rop[p] = 3'($urandom_range(0, 7));
        rpc[p] = $urandom;
        rimm[p] = $urandom;
        rtag[p] = TAG_W'($urandom);
      end
      rpred = 2'($urandom);
      i_req_valid = 2'($urandom);
      i_res_ready = ($urandom_range(0, 3) != 0);
      i_flush = ($urandom_range(0, 15) == 0);
      #1;
      ntotal++;
      if (o_req_ready !== exp_ready())
        $display("FAIL rand_ready_%0d: ready=%b want %b", c, o_req_ready, exp_ready());
      else npass++;
      tick();
      ntotal++;
      if (o_res_valid !== m_full)
        $display("FAIL rand_valid_%0d: valid=%b want %b", c, o_res_valid, m_full);
      else npass++;
      if (m_full) begin
        ntotal++;
        if ({o_res_taken, o_res_next_pc, o_res_tag, o_res_src, o_res_illegal} !==
            {m_taken, m_npc, m_tag, m_src, m_ill})
          $display("FAIL rand_result_%0d: taken=%b npc=%h tag=%h src=%b ill=%b want %b %h %h %b %b",
                   c, o_res_taken, o_res_next_pc, o_res_tag, o_res_src, o_res_illegal,
                   m_taken, m_npc, m_tag, m_src, m_ill);
        else npass++;
`ifdef BU_ARB_PREDICT_EN
        ntotal++;
        if (o_res_mispredict !== m_misp)
          $display("FAIL rand_mispredict_%0d: got %b want %b", c, o_res_mispredict, m_misp);
        else npass++;
`endif
      end
    end
    idle_drain();
  endtask

  initial begin
    for (int p = 0; p < 2; p++) set_port(p, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, '0);
    model_reset();
    test_reset();
    test_branch_ops();
    test_round_robin();
    test_stall();
    test_flush();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
